// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : stream_fifo
//  Purpose  : Ready/valid synchronous FIFO, FWFT or registered read, any depth,
//             threshold flags, synchronous flush and high-water-mark monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 32,
    parameter int FWFT       = 1,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [CNT_WIDTH-1:0]  max_count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o
);

    localparam int                   c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0]   c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_DEPTH = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_AF    = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] c_AE    = CNT_WIDTH'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_max;
    logic [CNT_WIDTH-1:0]  w_count_nxt;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;

    // Handshakes qualify only on registered occupancy, so a same-cycle pop
    // never frees a slot and a same-cycle push never feeds a pop.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_push  = in_valid_i & ~w_full;
    assign w_pop   = out_ready_i & ~w_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push & ~w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop & ~w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_max    <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_max    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            if (w_count_nxt > r_max) begin
                r_max <= w_count_nxt;
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push & ~flush_i) begin
            r_mem[r_wr_ptr] <= in_data_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign out_valid_o = ~w_empty;
            assign out_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_reg_read
            logic                  r_out_valid;
            logic [DATA_WIDTH-1:0] r_out_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                end else if (flush_i) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                end else begin
                    r_out_valid <= w_pop;
                    if (w_pop) begin
                        r_out_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign out_valid_o = r_out_valid;
            assign out_data_o  = r_out_data;
        end
    endgenerate

    assign in_ready_o     = ~w_full;
    assign count_o        = r_count;
    assign max_count_o    = r_max;
    assign empty_o        = w_empty;
    assign full_o         = w_full;
    assign almost_empty_o = (r_count <= c_AE);
    assign almost_full_o  = (r_count >= c_AF);

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_fifo
//  Purpose  : Scoreboard bench for three stream_fifo configurations
//             (FWFT depth 32, FWFT depth 5, registered-read depth 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_fifo;

    localparam int c_DEP [3] = '{32, 5, 8};
    localparam int c_FW  [3] = '{1, 1, 0};
    localparam int c_AF  [3] = '{30, 3, 6};
    localparam int c_AE  [3] = '{1, 1, 1};

    typedef struct {
        logic         rdy, vld, emp, ful, ae, af;
        logic [127:0] dat;
        int           cnt, mx;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         fl_a, iv_a, or_a, rdy_a, vld_a, emp_a, ful_a, ae_a, af_a;
    logic [127:0] id_a, od_a;
    logic [5:0]   cnt_a, mx_a;
    logic         fl_b, iv_b, or_b, rdy_b, vld_b, emp_b, ful_b, ae_b, af_b;
    logic [127:0] id_b, od_b;
    logic [2:0]   cnt_b, mx_b;
    logic         fl_c, iv_c, or_c, rdy_c, vld_c, emp_c, ful_c, ae_c, af_c;
    logic [127:0] id_c, od_c;
    logic [3:0]   cnt_c, mx_c;

    stream_fifo #(.DEPTH(32), .FWFT(1)) u_a (
        .clk(clk), .rst(rst), .flush_i(fl_a), .in_valid_i(iv_a), .in_data_i(id_a),
        .in_ready_o(rdy_a), .out_valid_o(vld_a), .out_data_o(od_a), .out_ready_i(or_a),
        .count_o(cnt_a), .max_count_o(mx_a), .empty_o(emp_a), .full_o(ful_a),
        .almost_empty_o(ae_a), .almost_full_o(af_a));

    stream_fifo #(.DEPTH(5), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .flush_i(fl_b), .in_valid_i(iv_b), .in_data_i(id_b),
        .in_ready_o(rdy_b), .out_valid_o(vld_b), .out_data_o(od_b), .out_ready_i(or_b),
        .count_o(cnt_b), .max_count_o(mx_b), .empty_o(emp_b), .full_o(ful_b),
        .almost_empty_o(ae_b), .almost_full_o(af_b));

    stream_fifo #(.DEPTH(8), .FWFT(0)) u_c (
        .clk(clk), .rst(rst), .flush_i(fl_c), .in_valid_i(iv_c), .in_data_i(id_c),
        .in_ready_o(rdy_c), .out_valid_o(vld_c), .out_data_o(od_c), .out_ready_i(or_c),
        .count_o(cnt_c), .max_count_o(mx_c), .empty_o(emp_c), .full_o(ful_c),
        .almost_empty_o(ae_c), .almost_full_o(af_c));

    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] sb [3][$];
    int           mc [3];
    int           mmax [3];
    logic [127:0] mlast [3];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic obs_t obs(input int d);
        obs_t o;
        case (d)
            0: begin
                o.rdy = rdy_a; o.vld = vld_a; o.emp = emp_a; o.ful = ful_a;
                o.ae = ae_a; o.af = af_a; o.dat = od_a; o.cnt = int'(cnt_a); o.mx = int'(mx_a);
            end
            1: begin
                o.rdy = rdy_b; o.vld = vld_b; o.emp = emp_b; o.ful = ful_b;
                o.ae = ae_b; o.af = af_b; o.dat = od_b; o.cnt = int'(cnt_b); o.mx = int'(mx_b);
            end
            default: begin
                o.rdy = rdy_c; o.vld = vld_c; o.emp = emp_c; o.ful = ful_c;
                o.ae = ae_c; o.af = af_c; o.dat = od_c; o.cnt = int'(cnt_c); o.mx = int'(mx_c);
            end
        endcase
        return o;
    endfunction

    task automatic drive(input int d, input bit f, input bit v, input logic [127:0] dat, input bit r);
        case (d)
            0:       begin fl_a = f; iv_a = v; id_a = dat; or_a = r; end
            1:       begin fl_b = f; iv_b = v; id_b = dat; or_b = r; end
            default: begin fl_c = f; iv_c = v; id_c = dat; or_c = r; end
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            sb[d].delete();
            mc[d]    = 0;
            mmax[d]  = 0;
            mlast[d] = '0;
        end
    endtask

    task automatic chk_reset(input int d);
        obs_t o;
        o = obs(d);
        chk("rst_count", o.cnt, 0);
        chk("rst_max", o.mx, 0);
        chk("rst_out_valid", o.vld, 0);
        chk("rst_out_data", o.dat, 0);
        chk("rst_empty", o.emp, 1);
        chk("rst_full", o.ful, 0);
        chk("rst_in_ready", o.rdy, 1);
        chk("rst_almost_empty", o.ae, 1);
        chk("rst_almost_full", o.af, 0);
    endtask

    // One clock cycle on FIFO d; entered and left at posedge + 1.
    task automatic cyc(input int d, input bit f, input bit v, input logic [127:0] dat, input bit r);
        obs_t         o;
        logic [127:0] exp;
        bit           push, pop;
        drive(d, f, v, dat, r);
        @(negedge clk);
        o = obs(d);
        if (!f) begin
            chk("in_ready", o.rdy, mc[d] < c_DEP[d]);
            if (c_FW[d] != 0) begin
                chk("fwft_valid", o.vld, mc[d] > 0);
                if (mc[d] > 0) chk("fwft_data", o.dat, sb[d][0]);
                else           chk("fwft_data_empty", o.dat, 0);
            end
        end
        push = v && (mc[d] < c_DEP[d]);
        pop  = r && (mc[d] > 0);
        exp  = '0;
        if (f) begin
            sb[d].delete();
            mc[d] = 0; mmax[d] = 0; mlast[d] = '0;
            push = 0; pop = 0;
        end else begin
            if (pop)  exp = sb[d].pop_front();
            if (push) sb[d].push_back(dat);
            mc[d] = mc[d] + int'(push) - int'(pop);
            if (mc[d] > mmax[d]) mmax[d] = mc[d];
            if (pop && c_FW[d] == 0) mlast[d] = exp;
        end
        @(posedge clk);
        #1;
        o = obs(d);
        chk("count", o.cnt, mc[d]);
        chk("max_count", o.mx, mmax[d]);
        chk("empty", o.emp, mc[d] == 0);
        chk("full", o.ful, mc[d] == c_DEP[d]);
        chk("almost_empty", o.ae, mc[d] <= c_AE[d]);
        chk("almost_full", o.af, mc[d] >= c_AF[d]);
        if (c_FW[d] == 0) begin
            chk("reg_valid", o.vld, pop);
            chk("reg_data", o.dat, mlast[d]);
        end else if (f) begin
            chk("flush_valid", o.vld, 0);
        end
        drive(d, 0, 0, '0, 0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) drive(d, 0, 0, '0, 0);
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_reset(d);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // FWFT depth 32: fill 1..5 with consumer stalled, then drain in order
        for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 128'(i), 0);
        for (int i = 0; i < 5; i++)  cyc(0, 0, 0, '0, 1);

        // Depth 5: offset pointers, then three fill/overflow/drain rounds
        for (int i = 0; i < 2; i++) cyc(1, 0, 1, 128'('hE0 + i), 0);
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, '0, 1);
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 6; i++) cyc(1, 0, 1, 128'(rnd * 16 + i + 1), 0);
            for (int i = 0; i < 5; i++) cyc(1, 0, 0, '0, 1);
        end

        // Streaming at occupancy 2
        cyc(0, 0, 1, 128'h200, 0);
        cyc(0, 0, 1, 128'h201, 0);
        for (int i = 0; i < 100; i++) cyc(0, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 1);
        cyc(0, 0, 0, '0, 1);
        cyc(0, 0, 0, '0, 1);

        // Registered read: two pops then a strobe on empty
        cyc(2, 0, 1, 128'hA, 0);
        cyc(2, 0, 1, 128'hB, 0);
        for (int i = 0; i < 3; i++) cyc(2, 0, 0, '0, 1);

        // Flush at count 7 with both handshakes asserted
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 128'('h300 + i), 0);
        cyc(0, 1, 1, 128'hDEAD, 1);
        cyc(0, 0, 1, 128'h55, 0);
        cyc(0, 0, 0, '0, 1);
        cyc(2, 0, 1, 128'hC1, 0);
        cyc(2, 0, 1, 128'hC2, 0);
        cyc(2, 0, 0, '0, 1);
        cyc(2, 1, 1, 128'hBAD, 1);
        cyc(2, 0, 0, '0, 1);

        // Asynchronous reset mid-burst at count 4
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 128'('h400 + i), 0);
        drive(0, 0, 1, 128'h499, 0);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk_reset(d);
        model_reset();
        drive(0, 0, 0, '0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, 0, 1, 128'h77, 0);
        cyc(0, 0, 0, '0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
